// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int unsigned CNT_W_DEFAULT = 32;
  localparam int unsigned DIV_DEFAULT   = 49_999_999;  // 1 Hz from a 100 MHz clk

  typedef logic [CNT_W_DEFAULT-1:0] div_t;

  // Width of a channel select; a single-channel build still needs one bit.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: half-period counter, active and pending divide values, output clock.
// Optional tick pulse built only when CLKDIV_TICK_EN is defined.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned CntW       = CNT_W_DEFAULT,
  parameter int unsigned DefaultDiv = DIV_DEFAULT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            wr_i,
  input  logic [CntW-1:0] div_i,
  output logic            pend_o,
  output logic            clk_o,
  output logic            tick_o
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] div_q, div_d;
  logic [CntW-1:0] pdiv_q, pdiv_d;
  logic            pend_q, pend_d;
  logic            clk_q, clk_d;
  logic            at_end;
  logic            boundary;

  assign at_end   = (cnt_q == div_q);
  // High-to-low toggle closes a period; only there may a running channel change D.
  assign boundary = en_i && at_end && clk_q;

  always_comb begin
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    div_d  = div_q;
    pdiv_d = pdiv_q;
    pend_d = pend_q;

    if (!en_i) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (at_end) begin
      cnt_d = '0;
      clk_d = ~clk_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end

    if (pend_q && (!en_i || boundary)) begin
      div_d  = pdiv_q;
      pend_d = 1'b0;
    end else if (wr_i && !pend_q) begin
      pdiv_d = div_i;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      div_q  <= CntW'(DefaultDiv);
      pdiv_q <= '0;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      div_q  <= div_d;
      pdiv_q <= pdiv_d;
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;
  assign clk_o  = clk_q;

`ifdef CLKDIV_TICK_EN
  logic tick_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= en_i && at_end && !clk_q;
    end
  end

  assign tick_o = tick_q;
`else
  assign tick_o = 1'b0;
`endif

endmodule

// File: rtl/clock_divider_multi.sv
// NUM_CH independent clock dividers sharing one divide-value write port.
// Tick outputs are live only when CLKDIV_TICK_EN is defined.
module clock_divider_multi
  import clkdiv_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = CNT_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV = DIV_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         en,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [sel_w(NUM_CH)-1:0]  cfg_ch,
  input  logic [CNT_W-1:0]          cfg_div,
  output logic [NUM_CH-1:0]         clk_out,
  output logic [NUM_CH-1:0]         tick
);

  logic [NUM_CH-1:0] pend;
  logic [31:0]       ch_idx;

  assign ch_idx = 32'(cfg_ch);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr;
    assign wr = cfg_valid && (ch_idx == 32'(i));

    clkdiv_channel #(
      .CntW      (CNT_W),
      .DefaultDiv(DEFAULT_DIV)
    ) u_ch (
      .clk_i (clk),
      .rst_i (rst),
      .en_i  (en[i]),
      .wr_i  (wr),
      .div_i (cfg_div),
      .pend_o(pend[i]),
      .clk_o (clk_out[i]),
      .tick_o(tick[i])
    );
  end

  // Out-of-range selects match no channel, so they are accepted and dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_idx == i) cfg_ready = ~pend[i];
    end
  end

endmodule

// File: doc/clock_divider_multi.md
CLOCK_DIVIDER_MULTI -- requirements
Module: clock_divider_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32: width of divide value and per-channel counter.
REQ-003 SHALL have parameter DEFAULT_DIV, default 49_999_999: reset half-period value (1 Hz from 100 MHz clk).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  NUM_CH  per-channel run enable.
REQ-007 SHALL have port cfg_valid  input  1  divide-value write request.
REQ-008 SHALL have port cfg_ready  output  1  write accept; transfer when cfg_valid and cfg_ready are both high on a clk edge.
REQ-009 SHALL have port cfg_ch  input  $clog2(NUM_CH) (min 1)  target channel of write.
REQ-010 SHALL have port cfg_div  input  CNT_W  new half-period value.
REQ-011 SHALL have port clk_out  output  NUM_CH  registered divided clocks.
REQ-012 SHALL have port tick  output  NUM_CH  one-cycle pulse per output period (macro-gated, see REQ-027).

Function
REQ-013 SHALL give each channel an active half-period value D; clk_out toggles every D+1 enabled cycles, period 2*(D+1) clk cycles, 50% duty; D=0 gives divide-by-2.
REQ-014 SHALL implement per channel a counter 0..D; on a cycle with counter==D: counter->0, clk_out toggles; otherwise counter increments.
REQ-015 SHALL define the period boundary as the cycle clk_out goes high->low; each period is a low phase followed by a high phase.
REQ-016 SHALL, on channel enable (en sampled high after low), start with clk_out=0 and counter=0; first rising clk_out occurs D+1 cycles after the first cycle en is sampled high.
REQ-017 SHALL, on en sampled low, force clk_out=0 and counter=0 on the next edge; no partial-phase completion.
REQ-018 SHALL hold an accepted write as pending for its channel; a running channel loads it into D at the next period boundary, so no runt or stretched phase is ever produced.
REQ-019 SHALL load a pending value into D on the next edge when the target channel is disabled.
REQ-020 SHALL drive cfg_ready = NOT pending[cfg_ch], combinationally; a second write to the same channel stalls until the first is applied.
REQ-021 SHALL, for a write accepted on the same cycle as that channel's boundary, use the old D for the boundary and apply the new value at the following boundary.
REQ-022 SHALL accept and discard writes with cfg_ch >= NUM_CH (cfg_ready=1, no state change).
REQ-023 SHALL keep channels fully independent; a write or enable change on one channel never perturbs another.
REQ-024 SHALL wrap nothing silently: counter never exceeds D; cfg_div of all-ones is legal (period 2^(CNT_W+1)).

Reset
REQ-025 SHALL, while rst is high on an edge, set clk_out=0, tick=0, all counters=0, all D=DEFAULT_DIV, all pending=0; cfg_ready then reads 1.
REQ-026 SHALL, on rst mid-operation, discard pending writes; first edge after rst deassertion behaves as REQ-016 for every channel with en high.

Configuration
REQ-027 SHALL support macro CLKDIV_TICK_EN: defined -> tick[i] pulses high exactly one cycle, coincident with each low->high edge of clk_out[i]; undefined -> tick tied to 0 and its logic absent.

Structure
REQ-028 SHALL place in package clkdiv_pkg: default CNT_W constant, default DEFAULT_DIV constant, and typedef div_t (logic [CNT_W-1:0]).
REQ-029 SHALL implement one channel (counter, D, pending, clk_out, tick) as sub-module clkdiv_channel, instantiated NUM_CH times by generate loop.

Verification
REQ-030 SHALL cover: rst, en=1 on ch0 with DEFAULT_DIV overridden to 4 -> clk_out[0] rises 5 cycles after en, period 10 cycles, 50% duty.
REQ-031 SHALL cover: ch1 running D=2, write D=5 mid-high-phase -> current period completes at 6 cycles, next period 12 cycles, cfg_ready[ch1] low until the boundary.
REQ-032 SHALL cover: ch2 D=0 -> clk_out[2] toggles every cycle (divide-by-2); with CLKDIV_TICK_EN, tick[2] high one cycle every 2 cycles.
REQ-033 SHALL cover: ch3 disabled, write D=7 -> applied next edge, cfg_ready back to 1 next cycle; en=1 -> first rise after 8 cycles.
REQ-034 SHALL cover: rst pulsed while ch0 has pending write and clk_out high -> all clk_out 0 next edge, pending discarded, D back to DEFAULT_DIV.
REQ-035 SHALL cover: write with cfg_ch=NUM_CH (NUM_CH=4, cfg_ch width 2 requires NUM_CH=3 build) -> accepted, no channel changes period.
